universal_shift_reg: RTL
========================

// Module: universal_shift_reg
// PURPOSE
//   Parametrised register bank built from D flip-flop stages. WIDTH-bit register
//   with hold, shift-right, shift-left and parallel-load modes, optional rotate,
//   and synchronous preset. Supplies Q and Qn like a single flip-flop.
//   Serial data path for the counter and serial-link blocks in the flipflop
//   library.
// PARAMETERS
//   WIDTH      4        register width in bits (>=2)
//   RESET_VAL  0        WIDTH-bit value loaded by clr
//   ROTATE     0        1: shifted-out bit re-enters at the opposite end; sin_* ignored
// PORTS
//   clk      in   1       clock, rising-edge active
//   clr      in   1       asynchronous active-high reset
//   pr       in   1       synchronous preset: Q <= all ones at next edge
//   en       in   1       clock enable; 0 = hold
//   mode     in   2       00 hold, 01 shift right, 10 shift left, 11 parallel load
//   D        in   WIDTH   parallel load data
//   sin_r    in   1       serial in for shift right (enters at MSB)
//   sin_l    in   1       serial in for shift left (enters at LSB)
//   Q        out  WIDTH   register contents
//   Qn       out  WIDTH   ~Q, combinational
//   sout_r   out  1       Q[0], combinational (bit leaving on shift right)
//   sout_l   out  1       Q[WIDTH-1], combinational (bit leaving on shift left)
// BEHAVIOUR
//   - Reset: clr=1 forces Q=RESET_VAL immediately, without waiting for a clock.
//     Qn=~RESET_VAL. Q stays there while clr is high, regardless of other inputs.
//   - Release: the first rising edge after clr falls is a normal edge.
//   - Priority at each rising edge (clr low): pr > en=0 > mode.
//     - pr=1: Q <= {WIDTH{1'b1}}. Ignores en and mode.
//     - en=0: Q holds its value.
//     - mode 00: hold.
//     - mode 01: Q <= {sin_r, Q[WIDTH-1:1]}; with ROTATE=1, Q <= {Q[0], Q[WIDTH-1:1]}.
//     - mode 10: Q <= {Q[WIDTH-2:0], sin_l}; with ROTATE=1, Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
//     - mode 11: Q <= D.
//   - Latency: every register update takes effect 1 clk after the sampling edge.
//     Qn, sout_r and sout_l follow Q combinationally (0 cycles).
//   - Wrap-around: with ROTATE=1, WIDTH consecutive shifts in one direction
//     restore the original Q.
//   - Simultaneous pr and clr: clr wins; Q=RESET_VAL.
//   - clr asserted mid-shift sequence: the sequence is abandoned and nothing is
//     resumed after release.
//   - Unknown or X on mode with en=1: treated as hold. The bench flags it.
//   - No combinational path from D, sin_r or sin_l to any output.
// TESTING (WIDTH=4, RESET_VAL=0, ROTATE=0 unless noted)
//   1. clr=1 between clock edges, Q was 1010 -> Q=0000 and Qn=1111 at once.
//      Held while clr=1 with pr=1, mode=11.
//   2. pr=1, en=0 at edge -> Q=1111. Then pr=0, mode=11, D=0110, en=1 ->
//      Q=0110 next edge.
//   3. Q=0110, mode=01, sin_r=1, four edges -> 1011, 1101, 1110, 1111.
//      sout_r shows 0,1,1,0 before each edge.
//   4. Q=1001, mode=10, sin_l=0, two edges -> 0010, 0100. Then en=0, mode=11
//      for three edges -> Q remains 0100.
//   5. ROTATE=1, Q=1000: mode=01 x4 edges -> 0100, 0010, 0001, 1000.
//      mode=10 x1 -> 0001.
//   6. RESET_VAL=4'b0101: clr pulse during shift sequence -> Q=0101 async.
//      First edge after release applies the current mode normally.

Source files
------------

// File: rtl/universal_shift_reg.sv
// universal_shift_reg
//   WIDTH-bit register with hold, shift-right, shift-left and parallel-load
//   modes, optional rotate, synchronous preset and asynchronous clear.
//   Presents Q and Qn like a single flip-flop, plus the bit that would leave
//   on each shift direction.
//
// Ports
//   clk     in   1      rising-edge clock
//   clr     in   1      asynchronous active-high clear, loads RESET_VAL
//   pr      in   1      synchronous preset to all ones (beats en and mode)
//   en      in   1      clock enable, 0 = hold
//   mode    in   2      00 hold, 01 shift right, 10 shift left, 11 load D
//   D       in   WIDTH  parallel load data
//   sin_r   in   1      serial input entering at MSB on shift right
//   sin_l   in   1      serial input entering at LSB on shift left
//   Q       out  WIDTH  register contents
//   Qn      out  WIDTH  ~Q
//   sout_r  out  1      Q[0], bit leaving on shift right
//   sout_l  out  1      Q[WIDTH-1], bit leaving on shift left

module universal_shift_reg #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter bit               ROTATE    = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             pr,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             sout_r,
  output logic             sout_l
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] next_s;
  logic             shr_in_s;
  logic             shl_in_s;

  // Fill bits for each shift direction: with ROTATE the serial inputs are
  // ignored and the bit falling off one end re-enters at the other.
  always_comb begin
    shr_in_s = sin_r;
    shl_in_s = sin_l;
    if (ROTATE) begin
      shr_in_s = q_r[0];
      shl_in_s = q_r[WIDTH-1];
    end else begin
      shr_in_s = sin_r;
      shl_in_s = sin_l;
    end
  end

  // Next-state selection: preset beats enable, enable beats mode.
  // An unknown mode falls into the default arm and holds.
  always_comb begin
    next_s = q_r;
    if (pr) begin
      next_s = {WIDTH{1'b1}};
    end else if (!en) begin
      next_s = q_r;
    end else begin
      case (mode)
        2'b00:   next_s = q_r;
        2'b01:   next_s = {shr_in_s, q_r[WIDTH-1:1]};
        2'b10:   next_s = {q_r[WIDTH-2:0], shl_in_s};
        2'b11:   next_s = D;
        default: next_s = q_r;
      endcase
    end
  end

  // State register; clr acts immediately and dominates every other input.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q_r <= RESET_VAL;
    end else begin
      q_r <= next_s;
    end
  end

  // Outputs are pure functions of the register, so no path from D or the
  // serial inputs reaches them.
  assign Q      = q_r;
  assign Qn     = ~q_r;
  assign sout_r = q_r[0];
  assign sout_l = q_r[WIDTH-1];

endmodule
